// File: rtl/rect_raster_gen.sv
// rect_raster_gen: streams the outline or solid-fill pixels of a latched rectangle in raster order, clipped to the screen.
// Latency: first o_valid two cycles after i_start; then one pixel per cycle while i_ready is high.
// Backpressure: while o_valid & !i_ready the presented pixel (o_x/o_y/o_last) is held; no pixel is dropped or repeated.
//
// Ports:
//   clk, rst                 clock; synchronous active-low reset
//   i_x, i_y                 corner coordinate, captured by i_p1_load / i_p2_load (any state)
//   i_start, i_fill          begin a job from IDLE; i_fill=1 selects solid fill, 0 the BORDER_W outline
//   i_abort                  drop the job in SETUP/RUN, no o_done
//   i_ready                  downstream takes o_x/o_y this cycle
//   o_valid, o_x, o_y        pixel stream; o_x/o_y sit at IDLE_X/IDLE_Y when not streaming
//   o_last                   final pixel of the job
//   o_busy, o_done           SETUP or RUN; one-cycle pulse on normal completion
module rect_raster_gen #(
  parameter int COORD_W  = 16,
  parameter int BORDER_W = 3,
  parameter int SCR_W    = 800,
  parameter int SCR_H    = 600,
  parameter int IDLE_X   = 801,
  parameter int IDLE_Y   = 601
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  input  logic               i_p1_load,
  input  logic               i_p2_load,
  input  logic               i_start,
  input  logic               i_fill,
  input  logic               i_abort,
  input  logic               i_ready,
  output logic               o_valid,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y,
  output logic               o_last,
  output logic               o_busy,
  output logic               o_done
);

  // Bound arithmetic is one bit wider so a carry reads as "past the edge".
  localparam int EW = COORD_W + 1;
  localparam logic [EW-1:0]      ONE_E    = EW'(1);
  localparam logic [EW-1:0]      BW_E     = EW'(BORDER_W);
  localparam logic [EW-1:0]      TWO_BW_E = EW'(2 * BORDER_W);
  localparam logic [EW-1:0]      SCR_W_E  = EW'(SCR_W);
  localparam logic [EW-1:0]      SCR_H_E  = EW'(SCR_H);
  localparam logic [COORD_W-1:0] IDLE_X_C = COORD_W'(IDLE_X);
  localparam logic [COORD_W-1:0] IDLE_Y_C = COORD_W'(IDLE_Y);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_RUN} state_t;

  typedef struct packed {
    logic [COORD_W-1:0] xmin;
    logic [COORD_W-1:0] xmax;
    logic [COORD_W-1:0] ymin;
    logic [COORD_W-1:0] ymax;
  } box_t;

  state_t             state, state_nxt;
  logic [COORD_W-1:0] p1_x, p1_y, p2_x, p2_y;
  box_t               box_q, box_d;
  logic               solid_q, solid_d;
  logic [COORD_W-1:0] cur_x, cur_y;
  logic               done_q;

  logic [EW-1:0] xmin_e, xmax_e, ymin_e, ymax_e, cx_e, cy_e, nx, ny;
  logic          border_row, jump, row_end, job_end, off_screen, hs;

  // Normalise the corners; a box no wider or taller than two borders has no
  // interior, so it is walked as a solid fill.
  always_comb begin
    box_d.xmin = (p1_x < p2_x) ? p1_x : p2_x;
    box_d.xmax = (p1_x < p2_x) ? p2_x : p1_x;
    box_d.ymin = (p1_y < p2_y) ? p1_y : p2_y;
    box_d.ymax = (p1_y < p2_y) ? p2_y : p1_y;
    solid_d    = i_fill
              || (({1'b0, box_d.xmax} - {1'b0, box_d.xmin} + ONE_E) <= TWO_BW_E)
              || (({1'b0, box_d.ymax} - {1'b0, box_d.ymin} + ONE_E) <= TWO_BW_E);
  end

  // Next scan position. Interior rows jump from the end of the left border
  // straight to the start of the right border, so no cycle is wasted.
  always_comb begin
    xmin_e     = {1'b0, box_q.xmin};
    xmax_e     = {1'b0, box_q.xmax};
    ymin_e     = {1'b0, box_q.ymin};
    ymax_e     = {1'b0, box_q.ymax};
    cx_e       = {1'b0, cur_x};
    cy_e       = {1'b0, cur_y};
    // y > ymax-BORDER_W written as y+BORDER_W > ymax to avoid an underflow
    border_row = solid_q || (cy_e < ymin_e + BW_E) || (cy_e + BW_E > ymax_e);
    jump       = !border_row && (cx_e == xmin_e + BW_E - ONE_E);
    nx         = jump ? (xmax_e - BW_E + ONE_E) : (cx_e + ONE_E);
    row_end    = (nx > xmax_e) || (nx >= SCR_W_E);
    ny         = cy_e + ONE_E;
    job_end    = row_end && ((ny > ymax_e) || (ny >= SCR_H_E));
    off_screen = (xmin_e >= SCR_W_E) || (ymin_e >= SCR_H_E);
  end

  assign hs = (state == S_RUN) && i_ready;

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Abort takes priority over completion, so an aborted job never reports done.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (i_start) state_nxt = S_SETUP;
      S_SETUP: state_nxt = (i_abort || off_screen) ? S_IDLE : S_RUN;
      S_RUN:   if (i_abort || (hs && job_end)) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      p1_x    <= '0;
      p1_y    <= '0;
      p2_x    <= '0;
      p2_y    <= '0;
      box_q   <= '0;
      solid_q <= 1'b0;
      cur_x   <= '0;
      cur_y   <= '0;
      done_q  <= 1'b0;
    end else begin
      if (i_p1_load) begin
        p1_x <= i_x;
        p1_y <= i_y;
      end
      if (i_p2_load) begin
        p2_x <= i_x;
        p2_y <= i_y;
      end
      done_q <= 1'b0;
      case (state)
        S_IDLE: if (i_start) begin
          box_q   <= box_d;
          solid_q <= solid_d;
        end
        S_SETUP: begin
          cur_x  <= box_q.xmin;
          cur_y  <= box_q.ymin;
          done_q <= !i_abort && off_screen;
        end
        S_RUN: if (hs) begin
          if (job_end) begin
            done_q <= !i_abort;
          end else if (row_end) begin
            cur_x <= box_q.xmin;
            cur_y <= ny[COORD_W-1:0];
          end else begin
            cur_x <= nx[COORD_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_valid = 1'b0;
    o_last  = 1'b0;
    o_x     = IDLE_X_C;
    o_y     = IDLE_Y_C;
    o_busy  = (state != S_IDLE);
    o_done  = done_q;
    if (state == S_RUN) begin
      o_valid = 1'b1;
      o_x     = cur_x;
      o_y     = cur_y;
      o_last  = job_end;
    end
  end

endmodule
